// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: a byte-laned RAM with 1-cycle read latency plus an MMIO window for LED, NUM and TIMER.
// Optional feature macro: DSRAM_TIMER_EN adds the free-running TIMER register at offset F008.
module data_sram_resp #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  localparam int unsigned DEPTH   = 1 << RAM_AW;
  localparam logic [15:0] OFF_LED = 16'hF000;
  localparam logic [15:0] OFF_NUM = 16'hF004;
  localparam logic [15:0] OFF_TMR = 16'hF008;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic [15:0]       r_led;
  logic [31:0]       r_num;

  logic              w_mmio_hit;
  logic              w_wr;
  logic              w_led_sel;
  logic              w_num_sel;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       w_rd_mux;
  logic [31:0]       w_timer_rd;
  logic              w_unused;

  assign w_mmio_hit = (data_sram_addr[31:16] == MMIO_BASE);
  assign w_off      = {data_sram_addr[15:2], 2'b00};
  assign w_idx      = data_sram_addr[RAM_AW+1:2];
  assign w_wr       = data_sram_en && (data_sram_we != 4'b0000);
  assign w_led_sel  = w_mmio_hit && (w_off == OFF_LED);
  assign w_num_sel  = w_mmio_hit && (w_off == OFF_NUM);
  assign w_unused   = ^data_sram_addr[1:0];

`ifdef DSRAM_TIMER_EN
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
  logic        w_timer_sel;

  assign w_timer_sel = w_mmio_hit && (w_off == OFF_TMR);

  // Written lanes override the per-cycle increment.
  always_comb begin
    w_timer_nxt = r_timer + 32'd1;
    if (data_sram_en && w_timer_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) w_timer_nxt[8*i +: 8] = data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_timer <= 32'd0;
    else         r_timer <= w_timer_nxt;
  end

  assign w_timer_rd = r_timer;
`else
  assign w_timer_rd = 32'd0;
`endif

  // Read mux; RAM path returns the pre-write word on write cycles.
  always_comb begin
    w_rd_mux = r_mem[w_idx];
    if (w_mmio_hit) begin
      case (w_off)
        OFF_LED: w_rd_mux = {16'h0000, r_led};
        OFF_NUM: w_rd_mux = r_num;
        OFF_TMR: w_rd_mux = w_timer_rd;
        default: w_rd_mux = 32'd0;
      endcase
    end
  end

  // RAM array is not reset; writes are discarded while reset is held.
  always_ff @(posedge clk) begin
    if (resetn && w_wr && !w_mmio_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= 32'd0;
      r_led   <= 16'h0000;
      r_num   <= 32'd0;
    end else if (data_sram_en) begin
      r_rdata <= w_rd_mux;
      if (w_led_sel) begin
        if (data_sram_we[0]) r_led[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_we[1]) r_led[15:8] <= data_sram_wdata[15:8];
      end
      if (w_num_sel) begin
        for (int i = 0; i < 4; i++) begin
          if (data_sram_we[i]) r_num[8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led_out         = r_led;
  assign num_out         = r_num;

endmodule
